// File: rtl/bird_pkg.sv
// Shared definitions for the bird controller and its datapath: state codes and colour width.
package bird_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned COL_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = 4'd0,
        LEFT    = 4'd1,
        RIGHT   = 4'd2,
        UP      = 4'd3,
        DOWN    = 4'd4,
        CLEAR   = 4'd5,
        DRAW    = 4'd6,
        SHOT    = 4'd7,
        ESCAPE  = 4'd8,
        CHECK   = 4'd9,
        PREHOLD = 4'd11
    } bird_state_e;

endpackage

// File: rtl/bird_datapath_if.sv
// Controller/crosshair/VGA side signals of the bird datapath.
interface bird_datapath_if;
    import bird_pkg::*;

    logic [STATE_W-1:0] STATE;
    logic               trigger;
    logic [7:0]         cross_x;
    logic [6:0]         cross_y;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [COL_W-1:0]   vga_colour;
    logic               plot;
    logic               enableDraw;
    logic               shot;
    logic               outOfAmmo;
    logic               flying;
    logic [7:0]         hits;

    modport master (
        output STATE, trigger, cross_x, cross_y,
        input  vga_x, vga_y, vga_colour, plot, enableDraw, shot, outOfAmmo, flying, hits
    );

    modport slave (
        input  STATE, trigger, cross_x, cross_y,
        output vga_x, vga_y, vga_colour, plot, enableDraw, shot, outOfAmmo, flying, hits
    );

endinterface

// File: rtl/bird_datapath_sprite_sweep.sv
// Row-major pixel walker over a W x H sprite; restarts on request, stops after the last pixel.
module sprite_sweep #(
    parameter int unsigned W = 8,
    parameter int unsigned H = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_en,
    input  logic                                   i_restart,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0]   o_col_c,
    output logic [((H > 1) ? $clog2(H) : 1)-1:0]   o_row_c,
    output logic                                   o_fire_c,
    output logic                                   o_last_c,
    output logic                                   o_done_c
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_done;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_done;

    // A restart takes effect in the same cycle so pixel 0 is emitted immediately.
    always_comb begin
        w_col    = i_restart ? '0 : r_col;
        w_row    = i_restart ? '0 : r_row;
        w_done   = i_restart ? 1'b0 : r_done;
        o_fire_c = i_en && !w_done;
        o_last_c = o_fire_c && (w_col == CW'(W - 1)) && (w_row == RW'(H - 1));
    end

    assign o_col_c  = w_col;
    assign o_row_c  = w_row;
    assign o_done_c = w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_done <= 1'b0;
        end else if (o_fire_c) begin
            if (w_col == CW'(W - 1)) begin
                r_col <= '0;
                r_row <= o_last_c ? '0 : w_row + RW'(1);
            end else begin
                r_col <= w_col + CW'(1);
                r_row <= w_row;
            end
            r_done <= o_last_c;
        end else begin
            r_col  <= w_col;
            r_row  <= w_row;
            r_done <= w_done;
        end
    end

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: position, ammo and hit status, frame timing and the clear/draw sprite sweeps.
module bird_datapath
    import bird_pkg::*;
#(
    parameter int unsigned     SCREEN_W  = 160,
    parameter int unsigned     SCREEN_H  = 120,
    parameter int unsigned     SPRITE_W  = 8,
    parameter int unsigned     SPRITE_H  = 8,
    parameter int unsigned     STEP      = 2,
    parameter int unsigned     AMMO      = 3,
    parameter int unsigned     FRAME_DIV = 833333,
    parameter int unsigned     X_START   = 76,
    parameter int unsigned     Y_START   = 100,
    parameter logic [COL_W-1:0] BIRD_COL = 3'b110,
    parameter logic [COL_W-1:0] BG_COL   = 3'b011
) (
    input  logic             clk,
    input  logic             reset_n,
    bird_datapath_if.slave   bus
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned AW = $clog2(AMMO + 1);
    localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [XW-1:0] X_MAX  = XW'(SCREEN_W - SPRITE_W);
    localparam logic [YW-1:0] Y_MAX  = YW'(SCREEN_H - SPRITE_H);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);
    localparam logic [YW-1:0] STEP_Y = YW'(STEP);

    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic [AW-1:0]      r_ammo;
    logic               r_shot;
    logic               r_flying;
    logic [7:0]         r_hits;
    logic [FW-1:0]      r_frame;
    logic               r_trig_d;
    logic [STATE_W-1:0] r_prev_state;
    logic [XW-1:0]      r_vga_x;
    logic [YW-1:0]      r_vga_y;
    logic [COL_W-1:0]   r_vga_col;
    logic               r_plot;
    logic               r_enable_draw;
    logic               r_ed_given;

    logic [STATE_W-1:0] w_state;
    logic               w_state_chg;
    logic               w_tick;
    logic               w_respawn;
    logic               w_fire_ok;
    logic               w_hit;
    logic               w_ed;
    logic               w_px_fire;
    logic               w_px_last;
    logic               w_sweep_done;
    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;

    assign w_state     = bus.STATE;
    assign w_state_chg = (w_state != r_prev_state);
    assign w_tick      = (r_frame == FW'(FRAME_DIV - 1));
    assign w_respawn   = (w_state == HOLD) && !r_flying;

    // Shots only count while the bird is in play; unlisted codes freeze everything.
    assign w_fire_ok = bus.trigger && !r_trig_d && r_flying && (r_ammo != '0) &&
                       (w_state inside {HOLD, LEFT, RIGHT, UP, DOWN, CLEAR, DRAW});
    assign w_hit     = (bus.cross_x >= r_x) && (bus.cross_x <= r_x + XW'(SPRITE_W - 1)) &&
                       (bus.cross_y >= r_y) && (bus.cross_y <= r_y + YW'(SPRITE_H - 1));

    // Once per visit: CLEAR right after the sweep, DRAW on the first frame tick after it.
    assign w_ed = !w_state_chg && w_sweep_done && !r_ed_given &&
                  ((w_state == CLEAR) || ((w_state == DRAW) && w_tick));

    sprite_sweep #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_sweep (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_en      ((w_state == CLEAR) || (w_state == DRAW)),
        .i_restart (w_state_chg),
        .o_col_c   (w_col),
        .o_row_c   (w_row),
        .o_fire_c  (w_px_fire),
        .o_last_c  (w_px_last),
        .o_done_c  (w_sweep_done)
    );

    // Position: clamp by comparing before the add/subtract.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x <= XW'(X_START);
            r_y <= YW'(Y_START);
        end else if (w_respawn) begin
            r_x <= XW'(X_START);
            r_y <= YW'(Y_START);
        end else begin
            case (w_state)
                LEFT:    r_x <= (r_x >= STEP_X) ? r_x - STEP_X : '0;
                RIGHT:   r_x <= (r_x >= X_MAX - STEP_X) ? X_MAX : r_x + STEP_X;
                UP:      r_y <= (r_y >= STEP_Y) ? r_y - STEP_Y : '0;
                DOWN:    r_y <= (r_y >= Y_MAX - STEP_Y) ? Y_MAX : r_y + STEP_Y;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ammo   <= AW'(AMMO);
            r_shot   <= 1'b0;
            r_flying <= 1'b1;
            r_hits   <= '0;
        end else if (w_respawn) begin
            r_ammo   <= AW'(AMMO);
            r_shot   <= 1'b0;
            r_flying <= 1'b1;
        end else begin
            if (w_fire_ok) begin
                r_ammo <= r_ammo - AW'(1);
                if (w_hit) r_shot <= 1'b1;
            end
            // A SHOT visit lasting several cycles still scores a single hit.
            if (w_state == SHOT) begin
                r_flying <= 1'b0;
                if (r_flying) r_hits <= r_hits + 8'd1;
            end
            if (w_state == ESCAPE) r_flying <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame      <= '0;
            r_trig_d     <= 1'b0;
            r_prev_state <= '0;
            r_ed_given   <= 1'b0;
        end else begin
            r_frame      <= w_tick ? '0 : r_frame + FW'(1);
            r_trig_d     <= bus.trigger;
            r_prev_state <= w_state;
            r_ed_given   <= w_state_chg ? 1'b0 : (r_ed_given || w_ed);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vga_x       <= '0;
            r_vga_y       <= '0;
            r_vga_col     <= '0;
            r_plot        <= 1'b0;
            r_enable_draw <= 1'b0;
        end else begin
            if (w_px_fire) begin
                r_vga_x   <= r_x + XW'(w_col);
                r_vga_y   <= r_y + YW'(w_row);
                r_vga_col <= (w_state == DRAW) ? BIRD_COL : BG_COL;
            end
            r_plot        <= w_px_fire;
            r_enable_draw <= w_ed;
        end
    end

    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_col;
    assign bus.plot       = r_plot;
    assign bus.enableDraw = r_enable_draw;
    assign bus.shot       = r_shot;
    assign bus.outOfAmmo  = (r_ammo == '0) && !r_shot;
    assign bus.flying     = r_flying;
    assign bus.hits       = r_hits;

    logic w_unused;
    assign w_unused = w_px_last;

endmodule

// File: tb/tb_bird_datapath.sv
// Self-checking bench for bird_datapath: status vector tables plus scoreboarded sprite sweeps.
module tb_bird_datapath;
    import bird_pkg::*;

    localparam int FDIV = 100;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic [3:0] st;
        logic       trig;
        int         cx;
        int         cy;
        logic       e_shot;
        logic       e_oa;
        logic       e_fly;
        int         e_hits;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    pix_t q[$];
    vec_t vecs[22];

    bird_datapath_if bus ();

    bird_datapath #(.FRAME_DIV(FDIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release: the frame tick falls on every multiple of FDIV.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [3:0] st, input int n);
        bus.STATE = st;
        repeat (n) step();
        bus.STATE = HOLD;
        step();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " plot"},       int'(bus.plot), 0);
        chk({tag, " enableDraw"}, int'(bus.enableDraw), 0);
        chk({tag, " shot"},       int'(bus.shot), 0);
        chk({tag, " outOfAmmo"},  int'(bus.outOfAmmo), 0);
        chk({tag, " flying"},     int'(bus.flying), 1);
        chk({tag, " hits"},       int'(bus.hits), 0);
        chk({tag, " vga_x"},      int'(bus.vga_x), 0);
        chk({tag, " vga_y"},      int'(bus.vga_y), 0);
        chk({tag, " vga_colour"}, int'(bus.vga_colour), 0);
    endtask

    task automatic do_sweep(input logic [3:0] st, input int ex, input int ey, input int col);
        int t0, e_exp, e_got, nplot, bad_order;
        bit seen;
        t0 = edge_cnt + 1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                pix_t p;
                p.x = 8'(ex + c);
                p.y = 7'(ey + r);
                p.c = 3'(col);
                q.push_back(p);
            end
        end
        bus.STATE = st;
        if (st == CLEAR) e_exp = t0 + 64;
        else             e_exp = ((t0 + 64 + FDIV - 1) / FDIV) * FDIV;
        nplot = 0; bad_order = 0; seen = 0; e_got = -1;
        for (int k = 0; k < 64 + FDIV + 8 && !seen; k++) begin
            step();
            if (bus.plot) begin
                if (edge_cnt != t0 + nplot) bad_order++;
                if (q.size() == 0) begin
                    bad_order++;
                end else begin
                    pix_t p;
                    p = q.pop_front();
                    chk($sformatf("pixel %0d", nplot),
                        int'({bus.vga_x, bus.vga_y, bus.vga_colour}), int'(p));
                end
                nplot++;
            end
            if (bus.enableDraw) begin
                seen  = 1;
                e_got = edge_cnt;
            end
        end
        chk("enableDraw cycle", e_got, e_exp);
        chk("plot count", nplot, 64);
        chk("plot timing", bad_order, 0);
        chk("sweep queue left", q.size(), 0);
        step();
        chk("enableDraw single pulse", int'(bus.enableDraw), 0);
        chk("no resweep", int'(bus.plot), 0);
        q.delete();
        bus.STATE = HOLD;
        step();
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.STATE   = vecs[i].st;
            bus.trigger = vecs[i].trig;
            bus.cross_x = 8'(vecs[i].cx);
            bus.cross_y = 7'(vecs[i].cy);
            step();
            chk($sformatf("v%0d shot", i),      int'(bus.shot),      int'(vecs[i].e_shot));
            chk($sformatf("v%0d outOfAmmo", i), int'(bus.outOfAmmo), int'(vecs[i].e_oa));
            chk($sformatf("v%0d flying", i),    int'(bus.flying),    int'(vecs[i].e_fly));
            chk($sformatf("v%0d hits", i),      int'(bus.hits),      vecs[i].e_hits);
        end
        bus.trigger = 1'b0;
        bus.STATE   = HOLD;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Ammo exhaustion with bird at (10,20), then escape and respawn.
        vecs[0]  = '{HOLD,   1'b1, 100, 100, 1'b0, 1'b0, 1'b1, 0};
        vecs[1]  = '{HOLD,   1'b1, 100, 100, 1'b0, 1'b0, 1'b1, 0};
        vecs[2]  = '{HOLD,   1'b0, 100, 100, 1'b0, 1'b0, 1'b1, 0};
        vecs[3]  = '{HOLD,   1'b1, 100, 100, 1'b0, 1'b0, 1'b1, 0};
        vecs[4]  = '{HOLD,   1'b0, 100, 100, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{HOLD,   1'b1, 100, 100, 1'b0, 1'b1, 1'b1, 0};
        vecs[6]  = '{HOLD,   1'b0, 100, 100, 1'b0, 1'b1, 1'b1, 0};
        vecs[7]  = '{HOLD,   1'b1,  12,  22, 1'b0, 1'b1, 1'b1, 0};
        vecs[8]  = '{ESCAPE, 1'b0,  12,  22, 1'b0, 1'b1, 1'b0, 0};
        vecs[9]  = '{HOLD,   1'b0,  12,  22, 1'b0, 1'b0, 1'b1, 0};
        // Hit window edges, the hit itself, SHOT, respawn, hit on pre-move position.
        vecs[10] = '{4'd12,  1'b1,  12,  22, 1'b0, 1'b0, 1'b1, 0};
        vecs[11] = '{HOLD,   1'b0,  12,  22, 1'b0, 1'b0, 1'b1, 0};
        vecs[12] = '{HOLD,   1'b1,  18,  22, 1'b0, 1'b0, 1'b1, 0};
        vecs[13] = '{HOLD,   1'b0,  18,  22, 1'b0, 1'b0, 1'b1, 0};
        vecs[14] = '{HOLD,   1'b1,  12,  28, 1'b0, 1'b0, 1'b1, 0};
        vecs[15] = '{HOLD,   1'b0,  12,  28, 1'b0, 1'b0, 1'b1, 0};
        vecs[16] = '{HOLD,   1'b1,  17,  27, 1'b1, 1'b0, 1'b1, 0};
        vecs[17] = '{HOLD,   1'b0,  17,  27, 1'b1, 1'b0, 1'b1, 0};
        vecs[18] = '{SHOT,   1'b0,  17,  27, 1'b1, 1'b0, 1'b0, 1};
        vecs[19] = '{HOLD,   1'b0,  17,  27, 1'b0, 1'b0, 1'b1, 1};
        vecs[20] = '{LEFT,   1'b1,  83, 100, 1'b1, 1'b0, 1'b1, 1};
        vecs[21] = '{HOLD,   1'b0,  83, 100, 1'b1, 1'b0, 1'b1, 1};

        reset_n     = 1'b0;
        bus.STATE   = HOLD;
        bus.trigger = 1'b0;
        bus.cross_x = '0;
        bus.cross_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        reset_n = 1'b1;

        move(LEFT, 1);
        do_sweep(CLEAR, 74, 100, 3);
        move(LEFT, 49);
        do_sweep(CLEAR, 0, 100, 3);
        move(RIGHT, 5);
        move(UP, 60);
        do_sweep(CLEAR, 10, 0, 3);
        move(DOWN, 10);
        do_sweep(CLEAR, 10, 20, 3);
        do_sweep(DRAW, 10, 20, 6);

        run_vecs(0, 9);
        do_sweep(CLEAR, 76, 100, 3);
        move(LEFT, 33);
        move(UP, 40);
        run_vecs(10, 21);
        do_sweep(CLEAR, 74, 100, 3);

        move(RIGHT, 50);
        move(DOWN, 10);
        do_sweep(CLEAR, 152, 112, 3);

        // Reset in the middle of a DRAW sweep must drop plot without waiting for a clock.
        bus.STATE = DRAW;
        repeat (10) step();
        chk("plot mid-sweep", int'(bus.plot), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async reset");
        q.delete();
        bus.STATE = HOLD;
        step();
        step();
        reset_n = 1'b1;
        do_sweep(CLEAR, 76, 100, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bird_datapath.md
# bird_datapath

Datapath and responder for the bird controller state machine. Consumes the 4-bit bird `STATE` code and produces the `enableDraw`, `shot`, `outOfAmmo` and `flying` status inputs that the controller branches on. Holds bird position, ammo and hit status, and drives the VGA adapter's pixel-plot port for the clear and draw sprite sweeps. Sits between the bird controller, the trigger/crosshair logic and the VGA adapter.

## Interface
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `SPRITE_W`, 8: bird sprite width.
- `SPRITE_H`, 8: bird sprite height.
- `STEP`, 2: pixels moved per move state.
- `AMMO`, 3: shots per round.
- `FRAME_DIV`, 833333: clocks per frame tick (60 Hz at 50 MHz).
- `X_START`, 76 / `Y_START`, 100: spawn position.
- `BIRD_COL`, 3'b110 / `BG_COL`, 3'b011: sprite and background colours.

Ports:
- `clk` input 1: system clock.
- `reset_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `STATE` input 4: current controller state code.
- `trigger` input 1: fire button, already synchronised to `clk`.
- `cross_x` input 8 / `cross_y` input 7: crosshair position.
- `vga_x` output 8 / `vga_y` output 7 / `vga_colour` output 3 / `plot` output 1: VGA write port.
- `enableDraw` output 1: sweep-complete pulse.
- `shot` output 1: bird hit this round.
- `outOfAmmo` output 1: ammo exhausted with no hit.
- `flying` output 1: bird alive and in play.
- `hits` output 8: hit count since reset.

## Operation
- Reset values:
  - bird x/y = `X_START`/`Y_START`; ammo = `AMMO`; `flying` = 1.
  - `shot` = 0, `plot` = 0, `enableDraw` = 0, `hits` = 0.
  - `vga_*` = 0; sweep and frame counters = 0.
- Move states (one cycle each):
  - LEFT: x -= `STEP`, clamped at 0.
  - RIGHT: x += `STEP`, clamped at `SCREEN_W-SPRITE_W`.
  - UP: y -= `STEP`, clamped at 0.
  - DOWN: y += `STEP`, clamped at `SCREEN_H-SPRITE_H`.
  - Clamping is computed without underflow: compare before subtracting.
- CLEAR: sweep `SPRITE_W*SPRITE_H` pixels, row-major, at bird x/y with `BG_COL` and `plot`=1. After the last pixel, pulse `enableDraw` for one cycle.
- DRAW:
  - Same sweep with `BIRD_COL`.
  - After the last pixel, hold `plot`=0 until the next frame tick, then pulse `enableDraw` for one cycle.
  - `shot` and `outOfAmmo` are stable in that pulse cycle.
- Sweep counter clears on every `STATE` change. While `enableDraw` has pulsed and the state is unchanged, no re-sweep occurs.
- Trigger:
  - Rising edge = `trigger` high with previous-cycle `trigger` low.
  - Counts only when `flying`=1, ammo>0, and `STATE` is not SHOT, ESCAPE, CHECK or PREHOLD.
  - Each counted edge decrements ammo.
  - If the crosshair lies within [x, x+`SPRITE_W`-1] × [y, y+`SPRITE_H`-1], set `shot` (sticky).
  - The hit test uses the pre-update position when the edge coincides with a move state.
- `outOfAmmo` = (ammo==0) && !`shot`, combinational from registers.
- SHOT: `flying` <= 0 and `hits` += 1 (wraps at 255). ESCAPE: `flying` <= 0.
- Respawn: when `STATE`==HOLD and `flying`==0, on one cycle:
  - x/y to spawn position; ammo = `AMMO`; `shot` = 0; `flying` = 1.
- Unlisted codes (10, 12–15): hold all registers, `plot`=0.

## Timing
- Move update visible in x/y the cycle after the state is sampled.
- `vga_*`/`plot` are registered: first pixel appears 1 cycle after entering CLEAR/DRAW. A sweep occupies `SPRITE_W*SPRITE_H` consecutive cycles.
- `enableDraw`:
  - CLEAR: the cycle after the last plotted pixel.
  - DRAW: the first frame tick at or after sweep end.
  - Never asserted in other states.
- Frame counter free-runs from reset, independent of `STATE`.
- Trigger to `shot`/ammo update: 1 cycle. `outOfAmmo` follows ammo in the same cycle.
- Reset mid-sweep drops `plot` immediately (asynchronously).

## Structure
- Shared package `bird_pkg`, holding the state code constants used by the controller and this block:
  - HOLD=0, LEFT=1, RIGHT=2, UP=3, DOWN=4, CLEAR=5, DRAW=6, SHOT=7, ESCAPE=8, CHECK=9, PREHOLD=11.
  - The colour width constant.
- One sub-module `sprite_sweep`:
  - Row/column counter with start and done.
  - Outputs pixel offsets and a last-pixel flag.
  - Instantiated once.

## Test plan
- Reset, then hold `STATE`=LEFT 50 cycles from x=76 → x steps 74, 72, … and saturates at 0; no underflow wrap.
- `STATE`=CLEAR with bird at (10,20) → 64 `plot` cycles covering (10..17, 20..27) with colour 3'b011; `enableDraw` single pulse on cycle 65.
- DRAW with `FRAME_DIV`=100 → 64 plots of 3'b110, then `enableDraw` exactly at the next frame tick, then 0.
- Three trigger edges with crosshair off-bird → ammo 3→0 and `outOfAmmo`=1; a fourth edge changes nothing.
- Trigger with crosshair (12,22) on bird at (10,20) → `shot`=1 next cycle. Then SHOT → `flying`=0 and `hits`=1. Then HOLD → respawn at (76,100) with ammo 3, `shot`=0, `flying`=1.
- Assert `reset_n` low mid-DRAW sweep → `plot`=0 immediately; all outputs return to reset values.
